// File: rtl/minibus_ram_slave_if.sv
// rtl/minibus_ram_slave_if.sv - request/response bus bundle for minibus_ram_slave
interface minibus_ram_slave_if;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_wen;
  logic        req_ren;
  logic [1:0]  req_width;
  logic        res_ack;
  logic [31:0] res_rdata;
  logic        res_error;

  modport master (
    output req_addr, req_wdata, req_wen, req_ren, req_width,
    input  res_ack, res_rdata, res_error
  );

  modport slave (
    input  req_addr, req_wdata, req_wen, req_ren, req_width,
    output res_ack, res_rdata, res_error
  );
endinterface

// File: rtl/minibus_ram_slave.sv
// rtl/minibus_ram_slave.sv - wait-stated byte-lane RAM slave; optional fault checking under MINIBUS_RAM_ERR_EN
module minibus_ram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                CLK,
  input logic                nRST,
  minibus_ram_slave_if.slave bus
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [1:0]  cap_width;
  logic        cap_store;
  logic        ack_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             req_any;
  logic             enter_ack;
  logic             do_write;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [1:0]       acc_width;
  logic             acc_store;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [3:0]       be;
  logic [31:0]      lane_wdata;
  logic [31:0]      rd_shift;
  logic [31:0]      load_data;
  logic             fault;

  assign req_any = bus.req_wen | bus.req_ren;

  // With zero wait states ACK is entered on the capture edge itself, so the
  // access must be decoded from the live request rather than the capture regs.
  assign enter_ack = ((state == IDLE) && req_any && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (cnt == CNT_LAST));

  // Select the access being completed: live request in IDLE, captured one otherwise
  always_comb begin
    if (state == IDLE) begin
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_width = bus.req_width;
      acc_store = bus.req_wen;
    end else begin
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      acc_width = cap_width;
      acc_store = cap_store;
    end
  end

  // Lane decode: low address bits below the access size are ignored, width 3 acts as word
  always_comb begin
    offset     = acc_addr - BASE_ADDR;
    idx        = IDX_W'(offset >> 2);
    lane       = 2'b00;
    be         = 4'b1111;
    lane_wdata = acc_wdata;
    case (acc_width)
      2'd0: begin
        lane       = acc_addr[1:0];
        be         = 4'b0001 << lane;
        lane_wdata = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        lane       = {acc_addr[1], 1'b0};
        be         = 4'b0011 << lane;
        lane_wdata = {2{acc_wdata[15:0]}};
      end
      default: begin
        lane       = 2'b00;
        be         = 4'b1111;
        lane_wdata = acc_wdata;
      end
    endcase
    rd_shift = mem[idx] >> {lane, 3'b000};
    case (acc_width)
      2'd0:    load_data = {24'd0, rd_shift[7:0]};
      2'd1:    load_data = {16'd0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

`ifdef MINIBUS_RAM_ERR_EN
  logic err_q;

  // Fault on reserved width, misalignment, or an address past the end of storage
  always_comb begin
    fault = (acc_width == 2'd3) ||
            ((acc_width == 2'd1) && acc_addr[0]) ||
            ((acc_width == 2'd2) && (acc_addr[1:0] != 2'b00)) ||
            ((offset >> (IDX_W + 2)) != 32'd0);
  end

  assign bus.res_error = err_q;
`else
  assign fault         = 1'b0;
  assign bus.res_error = 1'b0;
`endif

  // Writes are qualified by nRST so a request held during reset cannot store
  assign do_write = enter_ack && acc_store && !fault && nRST;

  // Byte-lane store on the edge entering ACK; storage is deliberately not reset
  always_ff @(posedge CLK) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered ack/rdata/error outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_width <= 2'd0;
      cap_store <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'd0;
`ifdef MINIBUS_RAM_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      ack_q   <= enter_ack;
      rdata_q <= (enter_ack && !acc_store && !fault) ? load_data : 32'd0;
`ifdef MINIBUS_RAM_ERR_EN
      err_q   <= enter_ack && fault;
`endif
      case (state)
        IDLE: begin
          if (req_any) begin
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_width <= bus.req_width;
            cap_store <= bus.req_wen;
            cnt       <= 4'd0;
            state     <= (WAIT_STATES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            cnt   <= 4'd0;
            state <= ACK;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.res_ack   = ack_q;
  assign bus.res_rdata = rdata_q;

endmodule

// File: tb/tb_minibus_ram_slave.sv
// tb/tb_minibus_ram_slave.sv - randomized self-checking bench for minibus_ram_slave
module tb_minibus_ram_slave;

  localparam int unsigned DEPTH0 = 1024;
  localparam logic [31:0] BASE0  = 32'h0000_0000;
  localparam int unsigned WS0    = 2;
  localparam int unsigned DEPTH1 = 32;
  localparam logic [31:0] BASE1  = 32'h0000_1000;
  localparam int unsigned WS1    = 0;
`ifdef MINIBUS_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  minibus_ram_slave_if b0 ();
  minibus_ram_slave_if b1 ();

  minibus_ram_slave #(.DEPTH_WORDS(DEPTH0), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)) dut0 (
    .CLK(CLK), .nRST(nRST), .bus(b0)
  );
  minibus_ram_slave #(.DEPTH_WORDS(DEPTH1), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)) dut1 (
    .CLK(CLK), .nRST(nRST), .bus(b1)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mdl0 [DEPTH0];

  function automatic int unsigned m_idx(input logic [31:0] addr, input logic [31:0] base, input int unsigned depth);
    logic [31:0] off;
    off = addr - base;
    return (off / 4) % depth;
  endfunction

  function automatic logic m_fault(input logic [31:0] addr, input logic [1:0] width, input logic [31:0] base, input int unsigned depth);
    logic [31:0] off;
    off = addr - base;
    if (width == 2'd3) return 1'b1;
    if (width == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (width == 2'd2 && (addr % 4) != 0) return 1'b1;
    return longint'(off) >= 4 * longint'(depth);
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] width);
    logic [31:0] r;
    int lo;
    r = old;
    case (width)
      2'd0: begin lo = int'(addr % 4); r[8*lo +: 8] = wdata[7:0]; end
      2'd1: begin lo = int'((addr % 4) / 2) * 2; r[8*lo +: 16] = wdata[15:0]; end
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] word, input logic [31:0] addr, input logic [1:0] width);
    case (width)
      2'd0:    return (word >> (8 * (addr % 4))) & 32'h0000_00FF;
      2'd1:    return (word >> (16 * ((addr % 4) / 2))) & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  task automatic drive(input int sel, input logic [31:0] addr, input logic [31:0] wdata, input logic wen, input logic ren, input logic [1:0] width);
    if (sel == 0) begin
      b0.req_addr = addr; b0.req_wdata = wdata; b0.req_wen = wen; b0.req_ren = ren; b0.req_width = width;
    end else begin
      b1.req_addr = addr; b1.req_wdata = wdata; b1.req_wen = wen; b1.req_ren = ren; b1.req_width = width;
    end
  endtask

  function automatic logic s_ack(input int sel);
    return (sel == 0) ? b0.res_ack : b1.res_ack;
  endfunction

  function automatic logic [31:0] s_rdata(input int sel);
    return (sel == 0) ? b0.res_rdata : b1.res_rdata;
  endfunction

  function automatic logic s_err(input int sel);
    return (sel == 0) ? b0.res_error : b1.res_error;
  endfunction

  // Called at a negedge while the slave is idle; returns at the negedge after the ack cycle.
  task automatic access(input int sel, input logic wen, input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] width,
                        output int lat, output logic [31:0] rd, output logic err, output logic tail_ack,
                        output logic [31:0] tail_rd, output time t_ack);
    drive(sel, addr, wdata, wen, !wen, width);
    @(posedge CLK);
    @(negedge CLK);
    drive(sel, $urandom, $urandom, 1'b0, 1'b0, 2'($urandom));
    lat = -1; rd = 32'd0; err = 1'b0; t_ack = 0;
    for (int n = 0; n < 40; n++) begin
      if (s_ack(sel)) begin
        lat = n + 1; rd = s_rdata(sel); err = s_err(sel); t_ack = $time;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    tail_ack = s_ack(sel);
    tail_rd  = s_rdata(sel);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++; if (b0.res_ack !== 1'b0) begin n_errors++; $display("FAIL rst_ack0: got %b want 0", b0.res_ack); end
    n_checks++; if (b0.res_rdata !== 32'd0) begin n_errors++; $display("FAIL rst_rdata0: got %h want 0", b0.res_rdata); end
    n_checks++; if (b0.res_error !== 1'b0) begin n_errors++; $display("FAIL rst_err0: got %b want 0", b0.res_error); end
    n_checks++; if (b1.res_ack !== 1'b0) begin n_errors++; $display("FAIL rst_ack1: got %b want 0", b1.res_ack); end
    n_checks++; if (b1.res_rdata !== 32'd0) begin n_errors++; $display("FAIL rst_rdata1: got %h want 0", b1.res_rdata); end
    n_checks++; if (b1.res_error !== 1'b0) begin n_errors++; $display("FAIL rst_err1: got %b want 0", b1.res_error); end
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++; if (b0.res_ack !== 1'b0) begin n_errors++; $display("FAIL post_rst_ack: got %b want 0", b0.res_ack); end
  endtask

  task automatic test_word_write_read();
    int lat; logic [31:0] rd, trd; logic err, tack; time t;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, lat, rd, err, tack, trd, t);
    mdl0[4] = 32'hDEADBEEF;
    n_checks++; if (lat !== int'(WS0 + 1)) begin n_errors++; $display("FAIL ww_store_lat: got %0d want %0d", lat, WS0 + 1); end
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL ww_store_rdata: got %h want 0", rd); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL ww_store_err: got %b want 0", err); end
    access(0, 1'b0, 32'h10, $urandom, 2'd2, lat, rd, err, tack, trd, t);
    n_checks++; if (lat !== int'(WS0 + 1)) begin n_errors++; $display("FAIL ww_load_lat: got %0d want %0d", lat, WS0 + 1); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL ww_load_rdata: got %h want deadbeef", rd); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL ww_load_err: got %b want 0", err); end
    n_checks++; if (tack !== 1'b0) begin n_errors++; $display("FAIL ww_ack_pulse: got %b want 0", tack); end
    n_checks++; if (trd !== 32'd0) begin n_errors++; $display("FAIL ww_rdata_idle: got %h want 0", trd); end
  endtask

  task automatic test_lanes();
    int lat; logic [31:0] rd, trd; logic err, tack; time t;
    access(0, 1'b1, 32'h20, 32'h11223344, 2'd2, lat, rd, err, tack, trd, t);
    access(0, 1'b1, 32'h21, 32'h000000AA, 2'd0, lat, rd, err, tack, trd, t);
    mdl0[8] = 32'h1122AA44;
    access(0, 1'b0, 32'h22, $urandom, 2'd1, lat, rd, err, tack, trd, t);
    n_checks++; if (rd !== 32'h00001122) begin n_errors++; $display("FAIL lanes_half: got %h want 00001122", rd); end
    access(0, 1'b0, 32'h20, $urandom, 2'd2, lat, rd, err, tack, trd, t);
    n_checks++; if (rd !== 32'h1122AA44) begin n_errors++; $display("FAIL lanes_word: got %h want 1122aa44", rd); end
    access(0, 1'b0, 32'h21, $urandom, 2'd0, lat, rd, err, tack, trd, t);
    n_checks++; if (rd !== 32'h000000AA) begin n_errors++; $display("FAIL lanes_byte: got %h want 000000aa", rd); end
  endtask

  task automatic test_faults();
    int lat; logic [31:0] rd, trd; logic err, tack; time t;
    access(0, 1'b1, 32'h04, 32'hCAFE0001, 2'd2, lat, rd, err, tack, trd, t);
    mdl0[1] = 32'hCAFE0001;
    access(0, 1'b1, 32'h00, 32'h600DF00D, 2'd2, lat, rd, err, tack, trd, t);
    mdl0[0] = 32'h600DF00D;
    access(0, 1'b1, 32'h06, 32'h00000055, 2'd2, lat, rd, err, tack, trd, t);
    n_checks++; if (lat !== int'(WS0 + 1)) begin n_errors++; $display("FAIL mis_store_lat: got %0d want %0d", lat, WS0 + 1); end
`ifdef MINIBUS_RAM_ERR_EN
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL mis_store_err: got %b want 1", err); end
    access(0, 1'b0, 32'h04, $urandom, 2'd2, lat, rd, err, tack, trd, t);
    n_checks++; if (rd !== 32'hCAFE0001) begin n_errors++; $display("FAIL mis_keeps_old: got %h want cafe0001", rd); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL aligned_err: got %b want 0", err); end
    access(0, 1'b0, BASE0 + 4 * DEPTH0, $urandom, 2'd2, lat, rd, err, tack, trd, t);
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL oor_err: got %b want 1", err); end
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL oor_rdata: got %h want 0", rd); end
    n_checks++; if (lat !== int'(WS0 + 1)) begin n_errors++; $display("FAIL oor_lat: got %0d want %0d", lat, WS0 + 1); end
    access(0, 1'b0, 32'h04, $urandom, 2'd3, lat, rd, err, tack, trd, t);
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL w3_err: got %b want 1", err); end
`else
    mdl0[1] = 32'h00000055;
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL mis_store_err: got %b want 0", err); end
    access(0, 1'b0, 32'h04, $urandom, 2'd2, lat, rd, err, tack, trd, t);
    n_checks++; if (rd !== 32'h00000055) begin n_errors++; $display("FAIL mis_aligned_word: got %h want 00000055", rd); end
    access(0, 1'b0, 32'h05, $urandom, 2'd1, lat, rd, err, tack, trd, t);
    n_checks++; if (rd !== 32'h00000055) begin n_errors++; $display("FAIL mis_aligned_half: got %h want 00000055", rd); end
    access(0, 1'b0, BASE0 + 4 * DEPTH0, $urandom, 2'd2, lat, rd, err, tack, trd, t);
    n_checks++; if (rd !== 32'h600DF00D) begin n_errors++; $display("FAIL wrap_word0: got %h want 600df00d", rd); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL wrap_err: got %b want 0", err); end
    access(0, 1'b0, BASE0 + 4 * DEPTH0 + 32'h6, $urandom, 2'd3, lat, rd, err, tack, trd, t);
    n_checks++; if (rd !== 32'h00000055) begin n_errors++; $display("FAIL w3_as_word: got %h want 00000055", rd); end
`endif
  endtask

  task automatic test_reset_mid_op();
    int lat, n_acks; logic [31:0] rd, trd; logic err, tack; time t;
    access(0, 1'b1, 32'h30, 32'h0BADF00D, 2'd2, lat, rd, err, tack, trd, t);
    mdl0[12] = 32'h0BADF00D;
    drive(0, 32'h30, 32'h12345678, 1'b1, 1'b0, 2'd2);
    @(posedge CLK);
    @(negedge CLK);
    drive(0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
    nRST = 1'b0;
    #1;
    n_acks = 0;
    n_checks++; if (b0.res_rdata !== 32'd0) begin n_errors++; $display("FAIL midrst_rdata: got %h want 0", b0.res_rdata); end
    repeat (2) begin if (b0.res_ack) n_acks++; @(negedge CLK); end
    nRST = 1'b1;
    repeat (6) begin if (b0.res_ack) n_acks++; @(negedge CLK); end
    n_checks++; if (n_acks !== 0) begin n_errors++; $display("FAIL midrst_no_ack: got %0d acks want 0", n_acks); end
    access(0, 1'b0, 32'h30, $urandom, 2'd2, lat, rd, err, tack, trd, t);
    n_checks++; if (rd !== 32'h0BADF00D) begin n_errors++; $display("FAIL midrst_old_data: got %h want 0badf00d", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, trd, d, a; logic err, tack; time t_st, t_ld;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      a = BASE1 + 32'h40 + 32'(4 * i);
      access(1, 1'b1, a, d, 2'd2, lat, rd, err, tack, trd, t_st);
      n_checks++; if (lat !== int'(WS1 + 1)) begin n_errors++; $display("FAIL b2b_store_lat[%0d]: got %0d want %0d", i, lat, WS1 + 1); end
      access(1, 1'b0, a, $urandom, 2'd2, lat, rd, err, tack, trd, t_ld);
      n_checks++; if ((t_ld - t_st) / 10 !== 64'(WS1 + 2)) begin n_errors++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, (t_ld - t_st) / 10, WS1 + 2); end
      n_checks++; if (rd !== d) begin n_errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rd, d); end
      n_checks++; if (tack !== 1'b0) begin n_errors++; $display("FAIL b2b_pulse[%0d]: got %b want 0", i, tack); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, trd, d, addr, exp_rd; logic err, tack, st, exp_err; logic [1:0] w, ew; time t;
    int unsigned ix;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      access(0, 1'b1, 32'(4 * i), d, 2'd2, lat, rd, err, tack, trd, t);
      mdl0[i] = d;
      n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rnd_fill_err[%0d]: got %b want 0", i, err); end
    end
    for (int k = 0; k < 60; k++) begin
      st   = 1'($urandom_range(0, 1));
      w    = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 63)) + (($urandom_range(0, 3) == 0) ? 32'(4 * DEPTH0) : 32'd0);
      d    = $urandom;
      exp_err = ERR_EN && m_fault(addr, w, BASE0, DEPTH0);
      ix = m_idx(addr, BASE0, DEPTH0);
      ew = (w == 2'd3) ? 2'd2 : w;
      if (st) begin
        exp_rd = 32'd0;
        if (!exp_err) mdl0[ix] = m_merge(mdl0[ix], addr, d, ew);
      end else begin
        exp_rd = exp_err ? 32'd0 : m_extract(mdl0[ix], addr, ew);
      end
      access(0, st, addr, d, w, lat, rd, err, tack, trd, t);
      n_checks++; if (lat !== int'(WS0 + 1)) begin n_errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", k, lat, WS0 + 1); end
      n_checks++; if (rd !== exp_rd) begin n_errors++; $display("FAIL rnd_rdata[%0d] st=%b a=%h w=%0d: got %h want %h", k, st, addr, w, rd, exp_rd); end
      n_checks++; if (err !== exp_err) begin n_errors++; $display("FAIL rnd_err[%0d] a=%h w=%0d: got %b want %b", k, addr, w, err, exp_err); end
      n_checks++; if (tack !== 1'b0) begin n_errors++; $display("FAIL rnd_pulse[%0d]: got %b want 0", k, tack); end
    end
  endtask

  initial begin
    nRST = 1'b0;
    drive(0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
    drive(1, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
    test_reset();
    test_word_write_read();
    test_lanes();
    test_faults();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/minibus_ram_slave.md
MINIBUS_RAM_SLAVE -- requirements
Module: minibus_ram_slave

Interface
- REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words of storage (power of 2).
- REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
- REQ-003 The block SHALL have parameter WAIT_STATES, default 2, giving extra cycles between request capture and ack (0..15).
- REQ-004 The block SHALL have one clock and an asynchronous active-low reset. Ports are listed below as name, direction, width, meaning, with clock and reset first.
  - CLK  in  1  clock; all state updates on the rising edge.
  - nRST  in  1  reset; asynchronous assert, active low.
  - req_addr  in  32  byte address.
  - req_wdata  in  32  store data, right-justified.
  - req_wen  in  1  store request.
  - req_ren  in  1  load request.
  - req_width  in  2  access width: 0 = byte, 1 = half, 2 = word, 3 = reserved.
  - res_ack  out  1  one-cycle completion pulse.
  - res_rdata  out  32  load data.
  - res_error  out  1  access faulted; valid while res_ack = 1.

Function
- REQ-005 The FSM SHALL have states IDLE, WAIT and ACK.
- REQ-006 In IDLE with req_wen=1 or req_ren=1, the block SHALL capture addr, wdata, width and op on the clock edge (op is a store if req_wen=1, else a load).
- REQ-007 After capture, the FSM SHALL go to WAIT if WAIT_STATES>0, otherwise directly to ACK.
- REQ-008 In WAIT, a 4-bit counter SHALL count WAIT_STATES cycles, then the FSM SHALL go to ACK.
- REQ-009 The ack SHALL arrive WAIT_STATES+1 cycles after the capture edge.
- REQ-010 res_ack SHALL be a registered output that is 1 only in ACK, for exactly one cycle. It SHALL never depend combinationally on req_* signals.
- REQ-011 From ACK the FSM SHALL always return to IDLE. A request present in that IDLE cycle SHALL be captured normally, so the minimum spacing between acks is WAIT_STATES+2 cycles.
- REQ-012 Changes on req_* after capture SHALL be ignored until the next IDLE.
- REQ-013 Stores SHALL write on the edge entering ACK, using byte enables derived from the captured width and addr[1:0]:
  - byte writes lane addr[1:0];
  - half writes lanes {addr[1],0},{addr[1],1};
  - word writes all four lanes.
- REQ-014 For a load, res_rdata SHALL be registered on the edge entering ACK, and SHALL be zero during a store ack.
- REQ-015 Load data SHALL be the addressed lanes, right-justified and zero-extended (byte -> bits 7:0, half -> 15:0, word -> 31:0).
- REQ-016 Outside ACK, res_rdata SHALL be 0.
- REQ-017 The word index SHALL be (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- REQ-018 A load of a word written earlier SHALL return the new data, including when the load is captured in the IDLE cycle immediately after the store's ack.

Reset
- REQ-019 While nRST=0 the FSM SHALL be IDLE, the counter 0, res_ack=0, res_rdata=0 and res_error=0.
- REQ-020 Reset asserted during WAIT or ACK SHALL abort the transaction: no write occurs and no ack is issued.
- REQ-021 Storage contents SHALL NOT be reset.

Configuration
- REQ-022 With MINIBUS_RAM_ERR_EN defined, a fault SHALL be raised when any of these holds:
  - misalignment: half with addr[0]=1, or word with addr[1:0]!=0;
  - width=3;
  - addr outside BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1.
- REQ-023 On a fault with MINIBUS_RAM_ERR_EN defined, the block SHALL complete with the normal latency and res_error=1 in ACK. No write occurs and res_rdata=0.
- REQ-024 With MINIBUS_RAM_ERR_EN undefined:
  - res_error SHALL be tied to 0;
  - misaligned accesses SHALL force-align by clearing the low address bits;
  - width=3 SHALL be treated as word;
  - out-of-range addresses SHALL wrap via the truncated index.

Verification
- REQ-025 Word write then read: WAIT_STATES=2; store word 0xDEADBEEF to 0x10, then load word 0x10.
  - Required: each ack arrives 3 cycles after its capture; rdata=0xDEADBEEF; error=0.
- REQ-026 Byte/half lanes: word 0x11223344 at 0x20; store byte 0xAA to 0x21, then load half 0x22 and word 0x20.
  - Required: half load returns 0x00001122; word load returns 0x1122AA44.
- REQ-027 Back-to-back: WAIT_STATES=0; a store to 0x40 is acked and the load of 0x40 is presented in the next IDLE.
  - Required: the load is acked 2 cycles after the store ack with the new data.
- REQ-028 Fault (MINIBUS_RAM_ERR_EN defined): store word 0x55 to 0x06.
  - Required: ack with error=1; a later word load of 0x04 returns the old value.
- REQ-029 Fault (MINIBUS_RAM_ERR_EN defined): load from BASE_ADDR+4*DEPTH_WORDS.
  - Required: error=1, rdata=0.
- REQ-030 Reset mid-op: assert nRST=0 during WAIT of a store of 0x12345678 to 0x30.
  - Required: no ack; a later load of 0x30 returns the prior contents.
